// File: rtl/intel_vvp_icon_axi_slave.sv
// ICON receive-side AXI4-Stream slave: one-register or skid-buffer input stage plus packet framing sidebands.
// Optional upstream protocol checker enabled by INTEL_VVP_ICON_AXI_SLAVE_PROTOCOL_CHECK_EN.
package intel_vvp_icon_pkg;
  localparam int VVP_USER_KEEP_BITS = 2;
endpackage

module intel_vvp_icon_axi_slave
  import intel_vvp_icon_pkg::*;
#(
  parameter int DATA_WIDTH         = 24,
  parameter int IS_TOKEN_INTERFACE = 0,
  parameter int PIPELINE_READY     = 0,
  parameter int COUNT_WIDTH        = 16,
  localparam int KEEP_WIDTH        = (DATA_WIDTH + 7) / 8,
  localparam int USER_WIDTH        = (IS_TOKEN_INTERFACE > 0) ? 1 :
                                     ((VVP_USER_KEEP_BITS > KEEP_WIDTH) ? VVP_USER_KEEP_BITS : KEEP_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   axi_st_din_tvalid,
  input  logic [DATA_WIDTH-1:0]  axi_st_din_tdata,
  input  logic [USER_WIDTH-1:0]  axi_st_din_tuser,
  input  logic                   axi_st_din_tlast,
  output logic                   axi_st_din_tready,
  output logic                   dout_valid,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic [USER_WIDTH-1:0]  dout_user,
  output logic                   dout_last,
  output logic                   dout_sop,
  output logic [COUNT_WIDTH-1:0] dout_beat_index,
  input  logic                   dout_ready,
  output logic [1:0]             prot_err
);

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  localparam logic [COUNT_WIDTH-1:0] IDX_ONE = 1;

  logic                  din_tready;
  logic                  in_hs;
  logic                  out_hs;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [USER_WIDTH-1:0] o_user_q, o_user_d;
  logic                  o_last_q, o_last_d;
  state_t                state_q, state_d;
  logic [COUNT_WIDTH-1:0] idx_q, idx_d;

  assign in_hs             = axi_st_din_tvalid & din_tready;
  assign out_hs            = o_valid_q & dout_ready;
  assign axi_st_din_tready = din_tready;

  generate
    if (PIPELINE_READY == 0) begin : g_single
      assign din_tready = dout_ready | ~o_valid_q;

      always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_user_d  = o_user_q;
        o_last_d  = o_last_q;
        if (out_hs) begin
          o_valid_d = 1'b0;
        end
        if (in_hs) begin
          o_valid_d = 1'b1;
          o_data_d  = axi_st_din_tdata;
          o_user_d  = axi_st_din_tuser;
          o_last_d  = axi_st_din_tlast;
        end
      end
    end else begin : g_skid
      logic                  s_valid_q, s_valid_d;
      logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
      logic [USER_WIDTH-1:0] s_user_q, s_user_d;
      logic                  s_last_q, s_last_d;
      logic                  tready_q;

      // Registered ready: held low during reset, otherwise the complement of the skid occupancy.
      assign din_tready = tready_q;

      always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_user_d  = o_user_q;
        o_last_d  = o_last_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_user_d  = s_user_q;
        s_last_d  = s_last_q;
        if (out_hs) begin
          if (s_valid_q) begin
            o_data_d  = s_data_q;
            o_user_d  = s_user_q;
            o_last_d  = s_last_q;
            s_valid_d = 1'b0;
          end else begin
            o_valid_d = 1'b0;
          end
        end
        if (in_hs) begin
          if (!o_valid_q || (out_hs && !s_valid_q)) begin
            o_valid_d = 1'b1;
            o_data_d  = axi_st_din_tdata;
            o_user_d  = axi_st_din_tuser;
            o_last_d  = axi_st_din_tlast;
          end else begin
            s_valid_d = 1'b1;
            s_data_d  = axi_st_din_tdata;
            s_user_d  = axi_st_din_tuser;
            s_last_d  = axi_st_din_tlast;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_valid_q <= 1'b0;
          s_data_q  <= '0;
          s_user_q  <= '0;
          s_last_q  <= 1'b0;
          tready_q  <= 1'b0;
        end else begin
          s_valid_q <= s_valid_d;
          s_data_q  <= s_data_d;
          s_user_q  <= s_user_d;
          s_last_q  <= s_last_d;
          tready_q  <= ~s_valid_d;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (out_hs) begin
      if (o_last_q) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        state_d = ST_IN_PKT;
        if (idx_q != {COUNT_WIDTH{1'b1}}) begin
          idx_d = idx_q + IDX_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_user_q  <= '0;
      o_last_q  <= 1'b0;
      state_q   <= ST_IDLE;
      idx_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_user_q  <= o_user_d;
      o_last_q  <= o_last_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
    end
  end

  assign dout_valid      = o_valid_q;
  assign dout_data       = o_data_q;
  assign dout_user       = o_user_q;
  assign dout_last       = o_last_q;
  assign dout_sop        = o_valid_q & (state_q == ST_IDLE);
  assign dout_beat_index = idx_q;

`ifdef INTEL_VVP_ICON_AXI_SLAVE_PROTOCOL_CHECK_EN
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] chk_data_q;
  logic [USER_WIDTH-1:0] chk_user_q;
  logic                  chk_last_q;
  logic [1:0]            err_q, err_d;

  // A stalled beat must stay asserted and unchanged until accepted.
  always_comb begin
    err_d = err_q;
    if (stall_q) begin
      if (!axi_st_din_tvalid) begin
        err_d[0] = 1'b1;
      end else if ((axi_st_din_tdata != chk_data_q) || (axi_st_din_tuser != chk_user_q) ||
                   (axi_st_din_tlast != chk_last_q)) begin
        err_d[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q    <= 1'b0;
      chk_data_q <= '0;
      chk_user_q <= '0;
      chk_last_q <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      stall_q    <= axi_st_din_tvalid & ~din_tready;
      chk_data_q <= axi_st_din_tdata;
      chk_user_q <= axi_st_din_tuser;
      chk_last_q <= axi_st_din_tlast;
      err_q      <= err_d;
    end
  end

  assign prot_err = err_q;
`else
  assign prot_err = 2'b00;
`endif

endmodule

// File: tb/tb_intel_vvp_icon_axi_slave.sv
// Directed bench: dut_a (single register, 2-bit index) and dut_b (skid buffer, 16-bit index).
// Protocol-checker expectations follow INTEL_VVP_ICON_AXI_SLAVE_PROTOCOL_CHECK_EN.
module tb_intel_vvp_icon_axi_slave;
  import intel_vvp_icon_pkg::*;

  localparam int UW = (VVP_USER_KEEP_BITS > 3) ? VVP_USER_KEEP_BITS : 3;
`ifdef INTEL_VVP_ICON_AXI_SLAVE_PROTOCOL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk, rst;
  int   n_cmp, n_err;

  logic          a_tvalid, a_tlast, a_tready, a_dout_ready;
  logic [23:0]   a_tdata, a_dout_data;
  logic [UW-1:0] a_tuser, a_dout_user;
  logic          a_dout_valid, a_dout_last, a_dout_sop;
  logic [1:0]    a_idx, a_prot_err;

  logic          b_tvalid, b_tlast, b_tready, b_dout_ready;
  logic [23:0]   b_tdata, b_dout_data;
  logic [UW-1:0] b_tuser, b_dout_user;
  logic          b_dout_valid, b_dout_last, b_dout_sop;
  logic [15:0]   b_idx;
  logic [1:0]    b_prot_err;

  bit            sel_b;
  logic          obs_valid, obs_last, obs_sop, obs_tready;
  logic [23:0]   obs_data;
  logic [UW-1:0] obs_user;
  logic [15:0]   obs_idx;

  assign obs_valid  = sel_b ? b_dout_valid : a_dout_valid;
  assign obs_last   = sel_b ? b_dout_last  : a_dout_last;
  assign obs_sop    = sel_b ? b_dout_sop   : a_dout_sop;
  assign obs_tready = sel_b ? b_tready     : a_tready;
  assign obs_data   = sel_b ? b_dout_data  : a_dout_data;
  assign obs_user   = sel_b ? b_dout_user  : a_dout_user;
  assign obs_idx    = sel_b ? b_idx        : {14'b0, a_idx};

  intel_vvp_icon_axi_slave #(.DATA_WIDTH(24), .IS_TOKEN_INTERFACE(0), .PIPELINE_READY(0), .COUNT_WIDTH(2)) dut_a (
    .clk(clk), .rst(rst),
    .axi_st_din_tvalid(a_tvalid), .axi_st_din_tdata(a_tdata), .axi_st_din_tuser(a_tuser),
    .axi_st_din_tlast(a_tlast), .axi_st_din_tready(a_tready),
    .dout_valid(a_dout_valid), .dout_data(a_dout_data), .dout_user(a_dout_user), .dout_last(a_dout_last),
    .dout_sop(a_dout_sop), .dout_beat_index(a_idx), .dout_ready(a_dout_ready), .prot_err(a_prot_err)
  );

  intel_vvp_icon_axi_slave #(.DATA_WIDTH(24), .IS_TOKEN_INTERFACE(0), .PIPELINE_READY(1), .COUNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst),
    .axi_st_din_tvalid(b_tvalid), .axi_st_din_tdata(b_tdata), .axi_st_din_tuser(b_tuser),
    .axi_st_din_tlast(b_tlast), .axi_st_din_tready(b_tready),
    .dout_valid(b_dout_valid), .dout_data(b_dout_data), .dout_user(b_dout_user), .dout_last(b_dout_last),
    .dout_sop(b_dout_sop), .dout_beat_index(b_idx), .dout_ready(b_dout_ready), .prot_err(b_prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive(input bit sel, input logic v, input logic [23:0] d, input logic [UW-1:0] u, input logic l);
    if (sel) begin
      b_tvalid = v; b_tdata = d; b_tuser = u; b_tlast = l;
    end else begin
      a_tvalid = v; a_tdata = d; a_tuser = u; a_tlast = l;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b1, 24'h123, '0, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got %b want 0", a_dout_valid); end
    n_cmp++; if (a_dout_sop !== 1'b0 || a_idx !== 2'd0) begin n_err++; $display("FAIL rst_a_sop_idx got %b/%0d want 0/0", a_dout_sop, a_idx); end
    n_cmp++; if (a_dout_data !== 24'h0 || a_dout_last !== 1'b0) begin n_err++; $display("FAIL rst_a_data got %h/%b want 0/0", a_dout_data, a_dout_last); end
    n_cmp++; if (a_tready !== 1'b1) begin n_err++; $display("FAIL rst_a_tready got %b want 1", a_tready); end
    n_cmp++; if (b_tready !== 1'b0) begin n_err++; $display("FAIL rst_b_tready got %b want 0", b_tready); end
    n_cmp++; if (b_dout_valid !== 1'b0 || b_idx !== 16'd0) begin n_err++; $display("FAIL rst_b_valid_idx got %b/%0d want 0/0", b_dout_valid, b_idx); end
    n_cmp++; if (a_prot_err !== 2'b00 || b_prot_err !== 2'b00) begin n_err++; $display("FAIL rst_prot_err got %b/%b want 00/00", a_prot_err, b_prot_err); end
    drive(0, 1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    #1;
    n_cmp++; if (b_tready !== 1'b0) begin n_err++; $display("FAIL rst_release_b_tready got %b want 0", b_tready); end
    @(negedge clk);
    n_cmp++; if (b_tready !== 1'b1) begin n_err++; $display("FAIL rst_b_tready_rise got %b want 1", b_tready); end
    $display("reset released");
  endtask

  // Streams n beats back-to-back with dout_ready high and checks each one a cycle later.
  task automatic stream_check(input bit sel, input string name, input int n, input logic [23:0] base,
                              input logic [15:0] lastm, input logic [15:0] sopm, input logic [63:0] idxv);
    logic [3:0] e_idx;
    sel_b = sel;
    a_dout_ready = 1'b1;
    b_dout_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      @(posedge clk); #1;
      if (i < n) drive(sel, 1'b1, base + 24'(i), UW'(i), lastm[i]);
      else       drive(sel, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      if (i < n) begin
        n_cmp++; if (obs_tready !== 1'b1) begin n_err++; $display("FAIL %s tready beat%0d got %b want 1", name, i, obs_tready); end
      end
      if (i > 0) begin
        e_idx = idxv[4*(i-1) +: 4];
        n_cmp++; if (obs_valid !== 1'b1) begin n_err++; $display("FAIL %s valid beat%0d got %b want 1", name, i-1, obs_valid); end
        n_cmp++; if (obs_data !== base + 24'(i-1) || obs_user !== UW'(i-1)) begin n_err++; $display("FAIL %s data beat%0d got %h/%h want %h/%h", name, i-1, obs_data, obs_user, base + 24'(i-1), UW'(i-1)); end
        n_cmp++; if (obs_last !== lastm[i-1]) begin n_err++; $display("FAIL %s last beat%0d got %b want %b", name, i-1, obs_last, lastm[i-1]); end
        n_cmp++; if (obs_sop !== sopm[i-1]) begin n_err++; $display("FAIL %s sop beat%0d got %b want %b", name, i-1, obs_sop, sopm[i-1]); end
        n_cmp++; if (obs_idx !== {12'b0, e_idx}) begin n_err++; $display("FAIL %s idx beat%0d got %0d want %0d", name, i-1, obs_idx, e_idx); end
        $display("%s beat%0d data=%h last=%b sop=%b idx=%0d", name, i-1, obs_data, obs_last, obs_sop, obs_idx);
      end
    end
  endtask

  task automatic test_packet;
    stream_check(0, "pkt3_a", 3, 24'h000001, 16'h0004, 16'h0001, 64'h210);
    stream_check(1, "pkt3_b", 3, 24'h000001, 16'h0004, 16'h0001, 64'h210);
  endtask

  task automatic test_back_to_back;
    stream_check(1, "single_b", 4, 24'h000100, 16'h000F, 16'h000F, 64'h0);
    stream_check(0, "single_a", 3, 24'h000110, 16'h0007, 16'h0007, 64'h0);
  endtask

  task automatic test_saturate;
    // 6-beat packet then a 2-beat packet on the 2-bit counter.
    stream_check(0, "sat_a", 8, 24'h000200, 16'h00A0, 16'h0041, 64'h10333210);
  endtask

  task automatic test_skid;
    int k;
    int got;
    k = 0;
    got = 0;
    sel_b = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(posedge clk); #1;
      b_dout_ready = !(c >= 3 && c <= 6);
      if (k < 10) drive(1, 1'b1, 24'h000300 + 24'(k), UW'(k), k == 9);
      else        drive(1, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      if (c == 3 || c == 8) begin
        n_cmp++; if (b_tready !== 1'b1) begin n_err++; $display("FAIL skid tready cyc%0d got %b want 1", c, b_tready); end
      end
      if (c == 4 || c == 7) begin
        n_cmp++; if (b_tready !== 1'b0) begin n_err++; $display("FAIL skid tready cyc%0d got %b want 0", c, b_tready); end
      end
      if (c == 5) begin
        n_cmp++; if (b_dout_valid !== 1'b1 || b_dout_data !== 24'h000302) begin n_err++; $display("FAIL skid stall_hold got %b/%h want 1/000302", b_dout_valid, b_dout_data); end
      end
      if (b_tvalid && b_tready) k++;
      if (b_dout_valid && b_dout_ready) begin
        n_cmp++; if (b_dout_data !== 24'h000300 + 24'(got) || b_dout_last !== (got == 9)) begin n_err++; $display("FAIL skid order beat%0d got %h/%b want %h/%b", got, b_dout_data, b_dout_last, 24'h000300 + 24'(got), got == 9); end
        n_cmp++; if (b_dout_sop !== (got == 0) || b_idx !== 16'(got)) begin n_err++; $display("FAIL skid framing beat%0d got %b/%0d want %b/%0d", got, b_dout_sop, b_idx, got == 0, got); end
        $display("skid beat%0d data=%h sop=%b idx=%0d", got, b_dout_data, b_dout_sop, b_idx);
        got++;
      end
    end
    drive(1, 1'b0, '0, '0, 1'b0);
    n_cmp++; if (got !== 10) begin n_err++; $display("FAIL skid count got %0d want 10", got); end
  endtask

  task automatic test_protocol;
    logic [1:0] e01, e11;
    e01 = CHK ? 2'b01 : 2'b00;
    e11 = CHK ? 2'b11 : 2'b00;
    sel_b = 1'b0;
    @(posedge clk); #1;
    a_dout_ready = 1'b0;
    drive(0, 1'b1, 24'h0000AA, '0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b1, 24'h0000BB, '0, 1'b1);
    @(negedge clk);
    n_cmp++; if (a_tready !== 1'b0) begin n_err++; $display("FAIL prot stall_tready got %b want 0", a_tready); end
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 24'h0000BB, '0, 1'b1);
    @(negedge clk);
    n_cmp++; if (a_prot_err !== e01) begin n_err++; $display("FAIL prot drop got %b want %b", a_prot_err, e01); end
    $display("prot valid-drop prot_err=%b", a_prot_err);
    @(posedge clk); #1;
    drive(0, 1'b1, 24'h0000CC, '0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, 1'b0);
    a_dout_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (a_prot_err !== e11) begin n_err++; $display("FAIL prot change got %b want %b", a_prot_err, e11); end
    n_cmp++; if (a_dout_data !== 24'h0000AA || a_dout_sop !== 1'b1) begin n_err++; $display("FAIL prot held_beat got %h/%b want 0000aa/1", a_dout_data, a_dout_sop); end
    $display("prot data-change prot_err=%b", a_prot_err);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++; if (a_prot_err !== e11 || a_dout_valid !== 1'b0) begin n_err++; $display("FAIL prot sticky got %b/%b want %b/0", a_prot_err, a_dout_valid, e11); end
    rst = 1'b1;
    #1;
    n_cmp++; if (a_prot_err !== 2'b00) begin n_err++; $display("FAIL prot clear got %b want 00", a_prot_err); end
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_packet;
    sel_b = 1'b0;
    a_dout_ready = 1'b1;
    @(posedge clk); #1; drive(0, 1'b1, 24'h000401, '0, 1'b0);
    @(posedge clk); #1; drive(0, 1'b1, 24'h000402, '0, 1'b0);
    @(posedge clk); #1; drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    n_cmp++; if (a_dout_valid !== 1'b1 || a_dout_data !== 24'h000402 || a_idx !== 2'd1 || a_dout_sop !== 1'b0) begin n_err++; $display("FAIL midrst pre got %b/%h/%0d/%b want 1/000402/1/0", a_dout_valid, a_dout_data, a_idx, a_dout_sop); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (a_dout_valid !== 1'b0 || a_idx !== 2'd0 || a_dout_sop !== 1'b0) begin n_err++; $display("FAIL midrst async got %b/%0d/%b want 0/0/0", a_dout_valid, a_idx, a_dout_sop); end
    $display("midrst reset asserted valid=%b", a_dout_valid);
    #1 rst = 1'b0;
    @(posedge clk); #1; drive(0, 1'b1, 24'h000455, '0, 1'b0);
    @(negedge clk);
    n_cmp++; if (a_dout_valid !== 1'b0) begin n_err++; $display("FAIL midrst latency got %b want 0", a_dout_valid); end
    @(posedge clk); #1; drive(0, 1'b1, 24'h000456, '0, 1'b1);
    @(negedge clk);
    n_cmp++; if (a_dout_valid !== 1'b1 || a_dout_data !== 24'h000455 || a_dout_sop !== 1'b1 || a_idx !== 2'd0) begin n_err++; $display("FAIL midrst first got %b/%h/%b/%0d want 1/000455/1/0", a_dout_valid, a_dout_data, a_dout_sop, a_idx); end
    $display("midrst beat0 data=%h sop=%b idx=%0d", a_dout_data, a_dout_sop, a_idx);
    @(posedge clk); #1; drive(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    n_cmp++; if (a_dout_data !== 24'h000456 || a_dout_sop !== 1'b0 || a_idx !== 2'd1 || a_dout_last !== 1'b1) begin n_err++; $display("FAIL midrst second got %h/%b/%0d/%b want 000456/0/1/1", a_dout_data, a_dout_sop, a_idx, a_dout_last); end
    $display("midrst beat1 data=%h sop=%b idx=%0d", a_dout_data, a_dout_sop, a_idx);
    @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sel_b = 1'b0;
    rst = 1'b1;
    a_dout_ready = 1'b0;
    b_dout_ready = 1'b0;
    drive(0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0);
    test_reset;
    test_packet;
    test_back_to_back;
    test_saturate;
    test_skid;
    test_protocol;
    test_reset_mid_packet;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intel_vvp_icon_axi_slave.md
# intel_vvp_icon_axi_slave

Receive-side AXI4-Stream slave for the ICON interconnect, the counterpart to the ICON AXI master. Accepts beats from an upstream AXI4-Stream source, buffers them in a one- or two-entry register stage, and presents them on the internal `dout_*` valid/ready interface. It also tracks packet framing, providing start-of-packet and beat-index sidebands.

## Interface
- `DATA_WIDTH`, 24: tdata width in bits.
- `IS_TOKEN_INTERFACE`, 0: 1 sets the user width to 1 bit.
- `PIPELINE_READY`, 0:
  - 0 selects a single output register with combinational ready.
  - 1 selects a two-entry skid buffer with registered `axi_st_din_tready`.
- `COUNT_WIDTH`, 16: width of `dout_beat_index`.
- `USER_WIDTH` (localparam):
  - 1 if `IS_TOKEN_INTERFACE` > 0.
  - Otherwise max(`VVP_USER_KEEP_BITS`, ceil(`DATA_WIDTH`/8)), from `intel_vvp_icon_pkg`.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `axi_st_din_tvalid`  in  1  upstream beat valid.
- `axi_st_din_tdata`  in  DATA_WIDTH  upstream data.
- `axi_st_din_tuser`  in  USER_WIDTH  upstream user/keep.
- `axi_st_din_tlast`  in  1  last beat of packet.
- `axi_st_din_tready`  out  1  slave ready.
- `dout_valid`  out  1  internal beat valid.
- `dout_data`  out  DATA_WIDTH  internal data.
- `dout_user`  out  USER_WIDTH  internal user.
- `dout_last`  out  1  internal last.
- `dout_sop`  out  1  current `dout` beat is the first of its packet.
- `dout_beat_index`  out  COUNT_WIDTH  zero-based beat position within the packet, saturating.
- `dout_ready`  in  1  internal consumer ready.
- `prot_err`  out  2  sticky upstream protocol-violation flags (see Configuration).

## Operation
- Input handshake: `axi_st_din_tvalid & axi_st_din_tready`. Output handshake: `dout_valid & dout_ready`.
- PIPELINE_READY=0:
  - One register stage (O).
  - `axi_st_din_tready` = `dout_ready | ~dout_valid` (combinational).
  - An input handshake loads O.
- PIPELINE_READY=1:
  - Output register O plus skid register S.
  - `axi_st_din_tready` is registered and equals ~S_valid.
  - On input handshake, the beat goes to O if O is empty or is consumed in the same cycle; otherwise it goes to S.
  - On output handshake with S valid, S moves to O and S is cleared. Simultaneous input accept and S drain: S drains to O and the new beat goes to S. With S full, tready is already 0, so there is no input handshake.
- Ordering is strictly preserved. No beat is dropped or duplicated.
- Framing FSM, advanced on output handshake only:
  - States: IDLE (next beat is SOP) and IN_PKT.
  - IDLE→IN_PKT on a beat with `dout_last`=0.
  - Any state→IDLE on a beat with `dout_last`=1. A single-beat packet stays in IDLE.
  - `dout_sop` = `dout_valid` & (state==IDLE).
- Beat index:
  - 0 while in IDLE.
  - Increments on each non-last output handshake.
  - Saturates at 2^COUNT_WIDTH−1; no wrap.
  - Cleared to 0 on a last beat.
- While stalled (`dout_valid`=1, `dout_ready`=0), all `dout_*` outputs hold stable.

## Timing
- Reset values:
  - `dout_valid`=0; `dout_sop`=0; `dout_beat_index`=0; `prot_err`=0.
  - FSM=IDLE.
  - `dout_data`/`dout_user`/`dout_last`=0.
  - PIPELINE_READY=1: `axi_st_din_tready`=0 while `rst` is high; it rises on the first `clk` edge after deassertion.
  - PIPELINE_READY=0: `axi_st_din_tready`=1 (O is empty), but no beat is captured while `rst` is high.
- Latency: an input handshake at edge N gives `dout_valid`=1 after edge N (1 cycle) for both settings.
- Throughput: 1 beat/cycle sustained with `dout_ready` held at 1.
- PIPELINE_READY=1: `axi_st_din_tready` falls in the cycle after S fills, and there is no combinational path from `dout_ready` to tready.
- Reset asserted mid-packet: buffers are discarded immediately (asynchronous), FSM returns to IDLE, and the first beat after reset is flagged SOP.

## Configuration
- Macro `INTEL_VVP_ICON_AXI_SLAVE_PROTOCOL_CHECK_EN`.
- Defined: upstream checker that monitors the cycle after a stall (`tvalid`=1, `tready`=0). The flags are sticky until `rst`.
  - `prot_err[0]` sets if `tvalid` drops.
  - `prot_err[1]` sets if `tdata`, `tuser` or `tlast` changes.
- Undefined: `prot_err` is tied to 2'b00 and no checker registers are instantiated.

## Test plan
- Reset release, 3-beat packet (D=1,2,3, last on 3), `dout_ready`=1 → `dout_*` one cycle later; sop on D=1 only; index 0,1,2; last on D=3.
- PIPELINE_READY=1, stream of 10 beats, `dout_ready`=0 for cycles 3–6 → S fills, tready drops one cycle later, all 10 beats appear in order with no loss.
- Back-to-back single-beat packets (last=1 each) → `dout_sop`=1 on every beat, index always 0.
- COUNT_WIDTH=2, 6-beat packet → index 0,1,2,3,3,3; next packet restarts at 0 with sop.
- Async `rst` pulse mid-packet (after beat 2 of 4) → `dout_valid`=0 immediately; next accepted beat carries sop=1, index 0.
- Macro defined: stall, then `tvalid` drops → `prot_err`=2'b01; stall with `tdata` changed → `prot_err`=2'b11, held until reset.
